pipe_stage_skid: RTL
====================

// Module: pipe_stage_skid
// PURPOSE
//  Parametrised inter-stage pipeline register with valid/ready handshake and a 2-entry skid buffer.
//  Replaces the fixed-field stall-only stage registers (IF/ID, ID/EX, EX/MEM, MEM/WB) with one generic block.
//  Payload is split into DATA (operands, addresses, PC) and CTRL (ALUOp, Mem*, RegWrite, ...).
//  Adds backpressure without combinational ready paths, plus flush-to-bubble for hazard/branch kill.
// PARAMETERS
//  DATA_W      128   width of data payload (bits)
//  CTRL_W      16    width of control payload (bits)
//  CTRL_BUBBLE 0     CTRL_W-bit value driven on out_ctrl when no valid entry (NOP control)
// PORTS
//  clk        in   1       clock, all state updates on posedge
//  reset      in   1       synchronous, active-high reset
//  flush      in   1       kill all held entries this cycle (bubble insertion)
//  in_valid   in   1       upstream stage presents an entry
//  in_ready   out  1       block accepts an entry this cycle (registered)
//  in_data    in   DATA_W  data payload in
//  in_ctrl    in   CTRL_W  control payload in
//  out_valid  out  1       downstream entry valid
//  out_ready  in   1       downstream consumes the entry this cycle
//  out_data   out  DATA_W  data payload out (from main register)
//  out_ctrl   out  CTRL_W  control payload out; CTRL_BUBBLE when out_valid=0
//  occupancy  out  2       number of held entries, 0..2
// BEHAVIOUR
//  Storage: main reg (M) drives outputs; skid reg (S) catches an accepted entry when M is stalled.
//  Accept = in_valid & in_ready; Drain = out_valid & out_ready.
//  in_ready = ~S_valid, registered; never depends on out_ready combinationally.
//  States: EMPTY(occ 0) / ONE(M valid, occ 1) / TWO(M,S valid, occ 2).
//   EMPTY: Accept -> ONE (in -> M).
//   ONE: Accept&Drain -> ONE (in -> M); Accept&~Drain -> TWO (in -> S); ~Accept&Drain -> EMPTY.
//   TWO: in_ready=0; Drain -> ONE (S -> M, S cleared); ~Drain -> TWO (hold).
//  Latency: entry accepted in cycle N is on outputs in N+1 when M empty or draining; order strictly FIFO.
//  Throughput: one entry per cycle sustained when out_ready stays high.
//  Flush: priority over Accept/Drain; next cycle occ=0, out_valid=0, out_ctrl=CTRL_BUBBLE, in_ready=1.
//   Entry presented with flush is dropped; data regs keep old contents (don't-care, not cleared).
//  Reset: priority over flush; next cycle out_valid=0, in_ready=1, occupancy=0, out_ctrl=CTRL_BUBBLE,
//   out_data=0, S contents=0. Inputs ignored during reset cycle; reset mid-TWO discards both entries.
//  out_data/out_ctrl stable while out_valid=1 & out_ready=0 (no change until Drain).
//  No overflow possible: Accept cannot occur in TWO. Drain when EMPTY is impossible (out_valid=0).
//  Widths: occupancy = M_valid + S_valid, 2 bits, no wrap.
// TESTING
//  Reset: assert reset 1 cycle with in_valid=1 -> next cycle out_valid=0, in_ready=1, occupancy=0, out_data=0.
//  Stream: out_ready=1, in data 1..8 on consecutive cycles -> out_data 1..8 on cycles 1..8 after, no gaps.
//  Backpressure: out_ready=0, send A,B,C -> A,B taken, occupancy=2, in_ready=0, C held upstream; out_ready=1 -> A,B,C in order.
//  Flush in TWO: hold A,B, assert flush with in_valid=1 data D -> next cycle occ=0, out_ctrl=CTRL_BUBBLE, D never output.
//  Simultaneous: state ONE holding X, Accept Y with Drain -> X consumed, out_data=Y next cycle, occ=1.
//  Reset vs flush: reset and flush together in TWO -> reset values, then stream 5,6 -> outputs 5,6 intact.

Source files
------------

// File: rtl/pipe_stage_skid_if.sv
// ----------------------------------------------------------------------------
// pipe_stage_skid_if
//
// Purpose:
//   Valid/ready handshake bundle carrying one pipeline entry (data + control).
//   One instance sits on each side of a pipe_stage_skid stage.
//
// Signals:
//   valid  producer -> consumer  entry present this cycle
//   ready  consumer -> producer  consumer takes the entry this cycle
//   data   producer -> consumer  DATA_W-bit data payload (operands, PC, ...)
//   ctrl   producer -> consumer  CTRL_W-bit control payload (ALUOp, Mem*, ...)
//
// Modports:
//   master  drives valid/data/ctrl, samples ready  (producer side)
//   slave   samples valid/data/ctrl, drives ready  (consumer side)
// ----------------------------------------------------------------------------
interface pipe_stage_skid_if #(
    parameter int DATA_W = 128,
    parameter int CTRL_W = 16
);

    logic              valid;
    logic              ready;
    logic [DATA_W-1:0] data;
    logic [CTRL_W-1:0] ctrl;

    modport master (
        output valid,
        output data,
        output ctrl,
        input  ready
    );

    modport slave (
        input  valid,
        input  data,
        input  ctrl,
        output ready
    );

endinterface : pipe_stage_skid_if

// File: rtl/pipe_stage_skid.sv
// ----------------------------------------------------------------------------
// pipe_stage_skid
//
// Purpose:
//   Generic inter-stage pipeline register with valid/ready handshake and a
//   two-entry skid buffer. A main register (M) drives the outputs; a skid
//   register (S) catches an entry accepted while M is stalled. Upstream ready
//   is a flop output, so there is no combinational path from out_ready back to
//   in_ready. A flush turns the stage into a bubble on the next cycle.
//
// Ports:
//   clk        in      clock, all state updates on the rising edge
//   reset      in      synchronous active-high reset (beats flush)
//   flush      in      kill all held entries this cycle (beats accept/drain)
//   up         slave   upstream handshake: valid/data/ctrl in, ready out
//                      (ready is registered and equals "skid register empty")
//   dn         master  downstream handshake: valid/data/ctrl out, ready in
//                      (ctrl shows CTRL_BUBBLE whenever valid is low)
//   occupancy  out     number of held entries, 0..2
//
// Parameters:
//   DATA_W       data payload width
//   CTRL_W       control payload width
//   CTRL_BUBBLE  control value presented when no entry is valid (NOP)
// ----------------------------------------------------------------------------
module pipe_stage_skid #(
    parameter int                 DATA_W      = 128,
    parameter int                 CTRL_W      = 16,
    parameter logic [CTRL_W-1:0]  CTRL_BUBBLE = '0
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 flush,
    pipe_stage_skid_if.slave     up,
    pipe_stage_skid_if.master    dn,
    output logic [1:0]           occupancy
);

    // Fill level of the stage. ONE means only M holds an entry; TWO means
    // both M (older, on the outputs) and S (younger) hold entries.
    typedef enum logic [1:0] {
        ST_EMPTY = 2'd0,
        ST_ONE   = 2'd1,
        ST_TWO   = 2'd2
    } state_e;

    state_e            state_q,    state_d;
    logic              in_ready_q, in_ready_d;
    logic [DATA_W-1:0] m_data_q,   m_data_d;
    logic [CTRL_W-1:0] m_ctrl_q,   m_ctrl_d;
    logic [DATA_W-1:0] s_data_q,   s_data_d;
    logic [CTRL_W-1:0] s_ctrl_q,   s_ctrl_d;

    logic m_valid;
    logic accept;
    logic drain;

    // M holds an entry in both ONE and TWO.
    assign m_valid = (state_q != ST_EMPTY);

    // in_ready_q is a flop, so accept never depends on this cycle's out_ready.
    assign accept  = up.valid & in_ready_q;
    assign drain   = m_valid & dn.ready;

    // ------------------------------------------------------------------------
    // Next-state and datapath steering
    // ------------------------------------------------------------------------
    always_comb begin
        // NOTE: every signal gets a default before any branch so no path can
        // leave it unassigned; without this the tool infers a latch.
        state_d  = state_q;
        m_data_d = m_data_q;
        m_ctrl_d = m_ctrl_q;
        s_data_d = s_data_q;
        s_ctrl_d = s_ctrl_q;

        if (flush) begin
            // Drop everything, including an entry presented this cycle. The
            // payload registers keep stale contents; only validity matters.
            state_d = ST_EMPTY;
        end else begin
            unique case (state_q)
                ST_EMPTY: begin
                    if (accept) begin
                        m_data_d = up.data;
                        m_ctrl_d = up.ctrl;
                        state_d  = ST_ONE;
                    end
                end

                ST_ONE: begin
                    if (accept && drain) begin
                        // M is consumed and refilled in the same cycle.
                        m_data_d = up.data;
                        m_ctrl_d = up.ctrl;
                    end else if (accept) begin
                        // M is stalled; park the younger entry in S.
                        s_data_d = up.data;
                        s_ctrl_d = up.ctrl;
                        state_d  = ST_TWO;
                    end else if (drain) begin
                        state_d  = ST_EMPTY;
                    end
                end

                ST_TWO: begin
                    // in_ready_q is low here, so accept cannot occur.
                    if (drain) begin
                        m_data_d = s_data_q;
                        m_ctrl_d = s_ctrl_q;
                        state_d  = ST_ONE;
                    end
                end

                default: begin
                    state_d = ST_EMPTY;
                end
            endcase
        end

        // Ready for next cycle is "S will be empty".
        in_ready_d = (state_d != ST_TWO);
    end

    // ------------------------------------------------------------------------
    // State registers
    // ------------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (reset) begin
            // NOTE: payload registers are normally left unreset; here a reset
            // must present zero on out_data and clear S, so they are reset.
            state_q    <= ST_EMPTY;
            in_ready_q <= 1'b1;
            m_data_q   <= '0;
            m_ctrl_q   <= CTRL_BUBBLE;
            s_data_q   <= '0;
            s_ctrl_q   <= '0;
        end else begin
            // NOTE: non-blocking assignments so every flop samples the values
            // computed before this edge, independent of statement order.
            state_q    <= state_d;
            in_ready_q <= in_ready_d;
            m_data_q   <= m_data_d;
            m_ctrl_q   <= m_ctrl_d;
            s_data_q   <= s_data_d;
            s_ctrl_q   <= s_ctrl_d;
        end
    end

    // ------------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------------
    assign up.ready = in_ready_q;
    assign dn.valid = m_valid;
    assign dn.data  = m_data_q;
    // Downstream decoders see a NOP control word on bubbles.
    assign dn.ctrl  = m_valid ? m_ctrl_q : CTRL_BUBBLE;

    always_comb begin
        occupancy = 2'd0;
        unique case (state_q)
            ST_EMPTY: occupancy = 2'd0;
            ST_ONE:   occupancy = 2'd1;
            ST_TWO:   occupancy = 2'd2;
            default:  occupancy = 2'd0;
        endcase
    end

endmodule : pipe_stage_skid
